// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and SDRAM power-up sequencer: holds sys_rst until the
// synchronised lock flag is stable, then times the SDRAM power-up interval.
module pll_reset_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_CYCLES  = 1024,
  parameter int PWRUP_CYCLES = 20000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       sys_rst,
  output logic       sdram_cke,
  output logic       pwrup_done,
  output logic [7:0] lock_lost_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_PWRUP     = 3'd2,
    S_RUN       = 3'd3
  } state_e;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             lost_q, lost_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   cke_q, cke_d;
  logic                   done_q, done_d;

  // Stage p0: lock flag synchroniser (pll_locked is asynchronous to clk)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Stage p1: sequencer state, interval counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT_LOCK;
      cnt_q     <= '0;
      lost_q    <= '0;
      sys_rst_q <= 1'b1;
      cke_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lost_q    <= lost_d;
      sys_rst_q <= sys_rst_d;
      cke_q     <= cke_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    case (state_q)
      S_WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) begin
          state_d = S_STABLE;
        end
      end
      S_STABLE, S_PWRUP, S_RUN: begin
        // Lock loss outranks a restart request and is always counted
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          if (lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
          end
        end else if (soft_rst) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (state_q == S_STABLE) begin
          if (cnt_q == LOCK_LAST) begin
            state_d = S_PWRUP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (state_q == S_PWRUP) begin
          if (cnt_q == PWRUP_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they switch on the transition edge
    sys_rst_d = !((state_d == S_PWRUP) || (state_d == S_RUN));
    cke_d     = (state_d == S_RUN);
    done_d    = (state_d == S_RUN);
  end

  assign sys_rst       = sys_rst_q;
  assign sdram_cke     = cke_q;
  assign pwrup_done    = done_q;
  assign lock_lost_cnt = lost_q;
  assign state_dbg     = state_q;

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Sits directly downstream of the board PLL and runs in the 100 MHz system clock domain.
- Synchronises the PLL `locked` flag and requires lock to stay continuously stable before releasing system reset.
- After reset release, times the SDRAM power-up interval, then asserts CKE and a power-up-done level that the SDRAM controller waits on before its init sequence.
- Any loss of lock drops everything back into reset and is counted.

Parameters:
- SYNC_STAGES, 2, number of flops in the `locked` synchroniser chain; must be at least 2.
- LOCK_CYCLES, 1024, consecutive cycles `locked_s` must stay high before `sys_rst` releases; must be at least 1.
- PWRUP_CYCLES, 20000, cycles from `sys_rst` release to CKE and done assertion (200 us at 100 MHz); must be at least 1.
- CNT_W, 16, width of the shared interval counter; 2^CNT_W must exceed max(LOCK_CYCLES, PWRUP_CYCLES).

Ports:
- clk  input  1  system clock (PLL 100 MHz output).
- rst  input  1  synchronous active-high reset.
- pll_locked  input  1  raw PLL lock flag; asynchronous to clk.
- soft_rst  input  1  synchronous restart request; level-sensitive, sampled each cycle.
- sys_rst  output  1  registered active-high reset for downstream logic.
- sdram_cke  output  1  registered SDRAM clock enable.
- pwrup_done  output  1  registered level: power-up interval complete; SDRAM controller may start init.
- lock_lost_cnt  output  8  saturating count of lock losses since rst.
- state_dbg  output  3  current FSM state encoding.

Behaviour:
- Reset (rst=1 at a clk edge):
  - sync chain = 0, state = WAIT_LOCK, counter = 0.
  - sys_rst = 1, sdram_cke = 0, pwrup_done = 0, lock_lost_cnt = 0.
  - rst dominates all other inputs.
- Synchroniser: `pll_locked` passes through SYNC_STAGES flops to give `locked_s`. No logic may use `pll_locked` directly.
- State encodings: WAIT_LOCK=0, STABLE=1, PWRUP=2, RUN=3.
- WAIT_LOCK:
  - counter = 0, sys_rst = 1, cke = 0, done = 0.
  - `locked_s`=1 -> STABLE, counter = 0.
- STABLE:
  - sys_rst = 1; counter increments each cycle.
  - `locked_s`=0 -> WAIT_LOCK.
  - Counter == LOCK_CYCLES-1 with `locked_s`=1 -> PWRUP, counter = 0.
  - STABLE therefore lasts exactly LOCK_CYCLES cycles.
- PWRUP:
  - sys_rst = 0, cke = 0, done = 0; counter increments.
  - Counter == PWRUP_CYCLES-1 -> RUN.
- RUN: sys_rst = 0, sdram_cke = 1, pwrup_done = 1; holds indefinitely.
- Outputs are registered and change on the same edge as the state transition into the state that defines them.
- Latency:
  - First edge sampling `pll_locked`=1 to `sys_rst` falling: SYNC_STAGES+1+LOCK_CYCLES edges (1027 with defaults), provided lock holds.
  - `sys_rst` falling to cke/done rising: PWRUP_CYCLES edges.
- Lock loss (`locked_s`=0 in STABLE, PWRUP or RUN):
  - Next edge: state = WAIT_LOCK, sys_rst = 1, cke = 0, done = 0, counter = 0.
  - lock_lost_cnt increments, saturating at 255.
  - A loss in WAIT_LOCK does not count.
- soft_rst=1 with `locked_s`=1, in any state:
  - Next edge: state = STABLE, counter = 0, sys_rst = 1, cke = 0, done = 0.
  - The full stability and power-up sequence is re-run.
  - lock_lost_cnt is not incremented.
- Precedence: rst > lock loss > soft_rst > normal transitions. If soft_rst and lock loss occur together, lock loss wins and is counted.
- Held soft_rst: holding soft_rst high keeps the block in STABLE with counter = 0.
- Glitch filtering: a 1-cycle `locked_s` low in STABLE restarts the full LOCK_CYCLES count.
- Counter arithmetic: unsigned CNT_W bits; the compares above must terminate it, so it never wraps.
- Unused encodings 4–7: recover to WAIT_LOCK on the next edge with reset outputs.

Test Plan (LOCK_CYCLES=8, PWRUP_CYCLES=16, SYNC_STAGES=2 unless noted):
- Basic bring-up:
  - Stimulus: rst for 3 cycles, then `pll_locked`=1 from edge 0.
  - Required: sys_rst falls at edge 11; sdram_cke and pwrup_done rise at edge 27; state_dbg goes 0→1→2→3.
- Unstable lock:
  - Stimulus: `pll_locked` high 5 cycles, low 1 cycle, then high.
  - Required: return to WAIT_LOCK; lock_lost_cnt=1; sys_rst stays 1 until 11 edges after the re-rise.
- Loss in RUN:
  - Stimulus: drop `pll_locked` after done=1.
  - Required: sys_rst=1, cke=0, done=0 exactly SYNC_STAGES+1 edges after the drop; lock_lost_cnt increments.
- soft_rst in PWRUP:
  - Stimulus: assert soft_rst for 1 cycle while in PWRUP.
  - Required: next edge state=1, sys_rst=1; sys_rst re-releases 8 edges later; lock_lost_cnt unchanged.
- Saturation:
  - Stimulus: 300 lock-loss events in STABLE.
  - Required: lock_lost_cnt=255 and holds.
- Reset mid-operation:
  - Stimulus: rst=1 for 1 cycle while in RUN, `pll_locked` still 1.
  - Required: all outputs at reset values next edge; full sequence repeats with the same latencies as bring-up.
